// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, fetch-queue entry, sizes.
package instr_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } if_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC register hookup, instruction memory handshake, decode queue head.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [XLEN-1:0] PC_OUT;
    logic            PC_EN;
    logic [XLEN-1:0] PC_IN;
    logic            IMEM_REQ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_ACK;
    logic [XLEN-1:0] IMEM_RDATA;
    logic            REDIRECT;
    logic [XLEN-1:0] REDIRECT_PC;
    logic            IF_VALID;
    logic            IF_READY;
    logic [XLEN-1:0] IF_PC;
    logic [XLEN-1:0] IF_INSTR;
    logic            IF_FAULT;

    modport master (
        input  PC_OUT, IMEM_ACK, IMEM_RDATA, REDIRECT, REDIRECT_PC, IF_READY,
        output PC_EN, PC_IN, IMEM_REQ, IMEM_ADDR, IF_VALID, IF_PC, IF_INSTR, IF_FAULT
    );

    modport slave (
        output PC_OUT, IMEM_ACK, IMEM_RDATA, REDIRECT, REDIRECT_PC, IF_READY,
        input  PC_EN, PC_IN, IMEM_REQ, IMEM_ADDR, IF_VALID, IF_PC, IF_INSTR, IF_FAULT
    );

endinterface

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched {pc, instr, fault} entries with synchronous flush.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  if_entry_t              entry_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output if_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    // A full queue still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop_c  = pop_i && (count_q != '0);
        do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_c && !flush_i) begin
                mem_q[wr_ptr_q] <= entry_i;
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: next-PC selection, imem req/ack sequencing, decode-side queue.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned PC queues a fault instead of fetching).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
    parameter int unsigned     QUEUE_DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    instr_fetch_if.master ifb
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic [XLEN-1:0] seq_pc_c, fetch_addr_c;
    logic [CNT_W-1:0] q_count;
    logic            q_valid;
    if_entry_t       q_head, push_entry_c;
    logic            push_c, pop_c, flush_c;
    logic            credit_c, aligned_c, req_c;
`ifdef IF_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
    logic            fault_push_c;
`endif

    assign seq_pc_c = ifb.PC_OUT + XLEN'(INSTR_BYTES);
    assign credit_c = (q_count < CNT_W'(QUEUE_DEPTH));
    assign pop_c    = q_valid && ifb.IF_READY;

`ifdef IF_MISALIGN_TRAP_EN
    assign aligned_c    = (ifb.PC_OUT[1:0] == 2'b00);
    assign fetch_addr_c = ifb.PC_OUT;
    // One fault entry per misaligned target; trap_q holds the stage until a redirect.
    assign fault_push_c = (state_q == RUN) && !aligned_c && credit_c && !trap_q;
`else
    assign aligned_c    = 1'b1;
    assign fetch_addr_c = word_align(ifb.PC_OUT);
`endif

    // A new request leaves from RUN only with a free queue slot; WAIT keeps it asserted.
    always_comb begin
        req_c = 1'b0;
        unique case (state_q)
            RUN:     req_c = credit_c && aligned_c;
            WAIT:    req_c = 1'b1;
            default: req_c = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= BOOT;
            drop_addr_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
`ifdef IF_MISALIGN_TRAP_EN
            trap_q      <= trap_d;
`endif
        end
    end

    // Next state: a redirect with a request still unanswered must drain it in DROP.
    always_comb begin
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, WAIT: begin
                if (ifb.REDIRECT) begin
                    if (req_c && !ifb.IMEM_ACK) begin
                        state_d     = DROP;
                        drop_addr_d = fetch_addr_c;
                    end else begin
                        state_d = RUN;
                    end
                end else if (req_c) begin
                    state_d = ifb.IMEM_ACK ? RUN : WAIT;
                end
            end
            DROP: begin
                if (ifb.IMEM_ACK) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_comb begin
        trap_d = trap_q;
        if (state_q != BOOT && ifb.REDIRECT) begin
            trap_d = 1'b0;
        end else if (fault_push_c) begin
            trap_d = 1'b1;
        end
    end
`endif

    // Outputs: PC write, memory request and queue control; all quiet while in reset.
    always_comb begin
        ifb.PC_EN          = 1'b0;
        ifb.PC_IN          = '0;
        ifb.IMEM_REQ       = 1'b0;
        ifb.IMEM_ADDR      = '0;
        push_c             = 1'b0;
        flush_c            = 1'b0;
        push_entry_c.pc    = ifb.PC_OUT;
        push_entry_c.instr = ifb.IMEM_RDATA;
        push_entry_c.fault = 1'b0;
        if (!RST) begin
            unique case (state_q)
                BOOT: begin
                    ifb.PC_EN = 1'b1;
                    ifb.PC_IN = RESET_VEC;
                end
                RUN, WAIT: begin
                    ifb.IMEM_REQ = req_c;
                    if (req_c) ifb.IMEM_ADDR = fetch_addr_c;
                    if (ifb.REDIRECT) begin
                        ifb.PC_EN = 1'b1;
                        ifb.PC_IN = ifb.REDIRECT_PC;
                        flush_c   = 1'b1;
                    end else if (req_c && ifb.IMEM_ACK) begin
                        push_c    = 1'b1;
                        ifb.PC_EN = 1'b1;
                        ifb.PC_IN = seq_pc_c;
                    end
`ifdef IF_MISALIGN_TRAP_EN
                    else if (fault_push_c) begin
                        push_c             = 1'b1;
                        push_entry_c.instr = '0;
                        push_entry_c.fault = 1'b1;
                    end
`endif
                end
                DROP: begin
                    ifb.IMEM_REQ  = 1'b1;
                    ifb.IMEM_ADDR = drop_addr_q;
                    if (ifb.REDIRECT) begin
                        ifb.PC_EN = 1'b1;
                        ifb.PC_IN = ifb.REDIRECT_PC;
                        flush_c   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (flush_c),
        .push_i  (push_c),
        .entry_i (push_entry_c),
        .pop_i   (pop_c),
        .valid_o (q_valid),
        .head_o  (q_head),
        .count_o (q_count)
    );

    assign ifb.IF_VALID = q_valid;
    assign ifb.IF_PC    = q_head.pc;
    assign ifb.IF_INSTR = q_head.instr;
    assign ifb.IF_FAULT = q_head.fault;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that drives the PC register and consumes its output. Each cycle it decides the next PC (sequential +4, redirect from execute, or boot vector), issues word fetches to instruction memory over a req/ack handshake, and buffers returned {pc, instr} pairs in a small queue toward decode with valid/ready flow control. It sits between the PC register (upstream of its PC_IN/PC_EN) and the decode stage.

## Interface
- RESET_VEC, 32'h0000_0000, boot address written into PC after reset
- QUEUE_DEPTH, 2, fetch queue entries (power of two, ≥2)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- PC_OUT  in  32  current PC from PC register
- PC_EN  out  1  PC write enable
- PC_IN  out  32  next PC value
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  32  word-aligned fetch address
- IMEM_ACK  in  1  request accepted and IMEM_RDATA valid this cycle
- IMEM_RDATA  in  32  instruction word
- REDIRECT  in  1  branch/jump taken, flush
- REDIRECT_PC  in  32  redirect target
- IF_VALID  out  1  queue head valid
- IF_READY  in  1  decode accepts head
- IF_PC  out  32  PC of head instruction
- IF_INSTR  out  32  head instruction
- IF_FAULT  out  1  head is misaligned-fetch fault

## Operation
- States: BOOT, RUN, WAIT, DROP.
- BOOT: one cycle after RST deasserts; PC_EN=1, PC_IN=RESET_VEC; → RUN. No request.
- RUN: if credits available (queue occupancy < QUEUE_DEPTH), assert IMEM_REQ, IMEM_ADDR=PC_OUT. If IMEM_ACK same cycle: push {PC_OUT, IMEM_RDATA, 0}, PC_EN=1, PC_IN=PC_OUT+4, stay RUN; else → WAIT. No credit: IMEM_REQ=0, stay RUN.
- WAIT: hold IMEM_REQ=1, IMEM_ADDR stable (= PC_OUT, PC not written). On IMEM_ACK: push, PC_EN=1, PC_IN=PC_OUT+4, → RUN.
- DROP: redirect arrived with request outstanding. Hold IMEM_REQ=1 with the original address (registered) until IMEM_ACK; discard data; → RUN.
- REDIRECT (any state except BOOT): PC_EN=1, PC_IN=REDIRECT_PC, queue flushed, IF_VALID=0 next cycle. RUN/WAIT with no ack this cycle and request asserted → DROP; ack same cycle → data discarded, → RUN. In DROP: stay DROP, PC updated again.
- Priority: RST > REDIRECT > IMEM_ACK push > sequential issue.
- Queue: push and pop (IF_VALID && IF_READY) in same cycle allowed when full; credit check uses occupancy before pop. Flush overrides simultaneous push/pop.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- PC_EN=0 whenever no write listed above.

## Timing
- Reset values: state BOOT, PC_EN=0, PC_IN=0, IMEM_REQ=0, IMEM_ADDR=0, IF_VALID=0, IF_PC=0, IF_INSTR=0, IF_FAULT=0, queue empty.
- PC_EN/PC_IN, IMEM_REQ/IMEM_ADDR combinational from state, PC_OUT, IMEM_ACK, REDIRECT; queue outputs registered.
- Zero-wait memory (ACK same cycle as REQ): one fetch per cycle; entry visible on IF_VALID the cycle after ack.
- Redirect-to-request latency: request to REDIRECT_PC one cycle after REDIRECT (after DROP completes if outstanding).
- RST mid-WAIT: request abandoned immediately, memory side must tolerate dropped REQ on reset.

## Configuration
- IF_MISALIGN_TRAP_EN defined: in RUN, PC_OUT[1:0]≠0 issues no request; pushes {PC_OUT, 32'h0, 1} (needs credit), PC_EN=0, state held until redirect. Undefined: IMEM_ADDR={PC_OUT[31:2],2'b00}, IF_FAULT tied 0.

## Structure
- Package instr_fetch_pkg: fetch_state_t enum, if_entry_t struct {pc, instr, fault}, INSTR_BYTES=4.
- Sub-module fetch_queue: parameterized FIFO of if_entry_t with synchronous flush, push/pop, count output.

## Test plan
- Reset then release, RESET_VEC=32'h0000_1000 → BOOT cycle PC_EN=1, PC_IN=32'h1000; first IMEM_ADDR=32'h1000.
- Zero-wait memory, IF_READY=1, words 32'hA0..A3 → IF_PC 1000,1004,1008,100C back-to-back, one per cycle.
- IF_READY=0, depth 2 → exactly two acks, then IMEM_REQ=0 and PC_EN=0 held; IF_READY=1 resumes fetch at 32'h1008.
- 3-cycle ack latency, REDIRECT to 32'hDEADBEEC in cycle 1 of wait → DROP, late data 32'hBAD not queued, next IMEM_ADDR=32'hDEADBEEC.
- REDIRECT coincident with IMEM_ACK → data discarded, PC_IN=REDIRECT_PC, queue empty next cycle.
- With IF_MISALIGN_TRAP_EN, redirect to 32'h0000_2002 → no IMEM_REQ, IF_FAULT=1, IF_PC=32'h2002.
